// File: rtl/bus_addr_dec_seq.sv
// Registered address decoder: NUM_SLV contiguous 2**SPAN_W windows from 0x0,
// one-hot select held per transaction. Optional DEC_ERR_CNT_EN adds err_cnt.
module bus_addr_dec_seq #(
  parameter int ADDR_W  = 8,
  parameter int NUM_SLV = 4,
  parameter int SPAN_W  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               m_req,
  input  logic [ADDR_W-1:0]  m_addr,
  output logic [NUM_SLV-1:0] s_sel,
  output logic               busy,
  output logic               dec_err
`ifdef DEC_ERR_CNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  // Widened index so the NUM_SLV compare never truncates, even for tiny ADDR_W.
  localparam int IW = ADDR_W + 5;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  state_t             state, state_nx;
  logic [NUM_SLV-1:0] sel_nx, dec_sel;
  logic               err_nx;
  logic [IW-1:0]      idx;
  logic               mapped;

  assign idx    = IW'(m_addr >> SPAN_W);
  assign mapped = idx < IW'(NUM_SLV);

  always_comb begin
    dec_sel = '0;
    for (int k = 0; k < NUM_SLV; k++)
      dec_sel[k] = mapped && (idx == IW'(k));
  end

  always_comb begin
    state_nx = state;
    sel_nx   = s_sel;
    err_nx   = dec_err;
    case (state)
      IDLE: begin
        sel_nx = '0;
        err_nx = 1'b0;
        if (m_req) begin
          if (mapped) begin
            state_nx = ACTIVE;
            sel_nx   = dec_sel;
          end else begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!m_req) begin
          state_nx = IDLE;
          sel_nx   = '0;
        end
      end
      ERR: begin
        if (!m_req) begin
          state_nx = IDLE;
          err_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        sel_nx   = '0;
        err_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      s_sel   <= '0;
      dec_err <= 1'b0;
    end else begin
      state   <= state_nx;
      s_sel   <= sel_nx;
      dec_err <= err_nx;
    end
  end

  assign busy = (state != IDLE);

`ifdef DEC_ERR_CNT_EN
  // Counts IDLE->ERR entries only; saturates rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_cnt <= 8'h00;
    else if (state == IDLE && state_nx == ERR && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'h01;
  end
`endif

endmodule
